axi_ohs_regbank: RTL and testbench
==================================

Name: axi_ohs_regbank

Overview:
- Parametrised AXI4-Lite slave register bank for the OHS power-stage models (boost and successors).
- Provides N_CFG read/write configuration registers that drive model gains and sources, and N_MON read-only monitor registers fed from model state.
- Independent AW/W acceptance, SLVERR on illegal accesses, per-register write strobes, and an optional atomic monitor snapshot.
- Sits between the PS interconnect and the model datapath; one instance per model.

Parameters:
- N_CFG, 4, number of config registers; word index 0..N_CFG-1.
- N_MON, 5, number of monitor registers; word index N_CFG..N_CFG+N_MON-1.
- ADDR_WIDTH, 6, AXI byte address width; must satisfy 2^(ADDR_WIDTH-2) >= N_CFG+N_MON+1.
- CFG_RST_VAL, 32'h0, reset value of every config register.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  reset, asynchronous, active-low.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awvalid / s_axi_awready  in / out  1  write address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  write byte strobes.
- s_axi_wvalid / s_axi_wready  in / out  1  write data handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out / in  1  write response handshake.
- s_axi_araddr  in  ADDR_WIDTH  read address.
- s_axi_arvalid / s_axi_arready  in / out  1  read address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out / in  1  read data handshake.
- cfg_regs  out  32*N_CFG  config registers, flattened; register k at [32k+:32].
- cfg_wr_stb  out  N_CFG  one-cycle pulse per register on a committed write.
- mon_regs  in  32*N_MON  monitor inputs, flattened; monitor k at [32k+:32].

Behaviour:
Reset:
- Asynchronous assert; synchronous deassert handled upstream.
- All outputs reset to 0: awready, wready, bvalid, arready, rvalid, rdata, bresp, rresp, cfg_wr_stb.
- cfg_regs reset to CFG_RST_VAL; AW/W holding buffers reset to empty.
- Reset mid-transaction drops the transaction silently, with no register change.

Write path:
- One-entry holding buffer each for AW and W.
- awready = AW buffer empty; wready = W buffer empty (registered). AW and W may arrive in any order or cycle.
- Commit edge: both buffers full and (!bvalid || bready).
  - Word index = awaddr[ADDR_WIDTH-1:2].
  - If index < N_CFG: the register is updated with byte strobes applied (strobe 0 keeps the prior byte), cfg_wr_stb[index] pulses for exactly that cycle, and bresp = OKAY (2'b00).
  - Any other index, including the monitor region: no state change, no strobe pulse, bresp = SLVERR (2'b10).
  - bvalid sets on the commit edge; both buffers empty on the same edge.
- bvalid clears on bvalid && bready unless a new commit occurs on the same edge, in which case bvalid stays 1 with the new bresp.
- Minimum latency: AW+W accepted on edge N, commit on edge N+1, bvalid high after N+1.
- Sustained throughput is one write per 2 cycles with bready held high.
- wstrb = 0 on a valid config address: OKAY, register unchanged, strobe still pulses.

Read path:
- arready = !rvalid || rready.
- On the AR handshake edge, rdata/rresp are registered and rvalid sets.
  - Config index: current register value (reflects a write committed on an earlier edge), OKAY.
  - Monitor index: mon_regs word sampled at that edge, OKAY.
  - Other index: rdata = 0, SLVERR.
- rvalid clears on rvalid && rready with no new AR handshake.
- Back-to-back reads at one per cycle when rready is held high.
- rdata is held stable while rvalid && !rready.
- Read and write channels are independent; a simultaneous read and commit to the same config register returns the pre-write value.

Optional Feature:
- OHS_MON_SNAPSHOT_EN defined:
  - Adds a control word at index N_CFG+N_MON.
  - A committed write with wstrb[0]=1 and wdata[0]=1 copies all mon_regs into an internal snapshot bank on the commit edge; response is OKAY.
  - Monitor-region reads return snapshot values, not live inputs.
  - A read of the control word returns 0 with OKAY.
  - The snapshot bank resets to 0.
- Undefined:
  - Monitor reads are live.
  - Index N_CFG+N_MON is out of range: SLVERR for both read and write.

Test Plan:
- Reset, then write 0x3F800000 to 0x00 with wstrb=F, AW and W in the same cycle -> bvalid after 2 edges with bresp=00; cfg_regs[31:0]=0x3F800000; cfg_wr_stb=0001 for one cycle.
- W issued 3 cycles before AW to 0x04, wdata=0xAABBCCDD, wstrb=0101, prior value 0 -> register 1 = 0x00BB00DD; awready/wready deassert while their buffers hold data.
- Read 0x10 with mon_regs[31:0]=0x12345678 -> rdata=0x12345678, rresp=00; then read 0x3C -> rdata=0, rresp=10.
- Write to 0x10 (monitor region) -> bresp=10, no cfg_wr_stb pulse, read-back unchanged.
- bready held low for 5 cycles after a write, with a second AW/W issued -> second commit waits; one buffer-full stall; no lost or duplicated response.
- With OHS_MON_SNAPSHOT_EN: set mon 0 = 0x11, write 1 to 0x24, change mon 0 to 0x22, read 0x10 -> 0x11. Assert aresetn low mid-read -> rvalid=0 immediately.

Source files
------------

// File: rtl/axi_ohs_regbank.sv
// AXI4-Lite config/monitor register bank for the OHS power-stage models.
// Define OHS_MON_SNAPSHOT_EN to add a control word that latches a monitor snapshot.
module axi_ohs_regbank #(
    parameter int unsigned N_CFG       = 4,
    parameter int unsigned N_MON       = 5,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter logic [31:0] CFG_RST_VAL = 32'h0
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [32*N_CFG-1:0]   cfg_regs,
    output logic [N_CFG-1:0]      cfg_wr_stb,
    input  logic [32*N_MON-1:0]   mon_regs
);
    localparam int unsigned IW = ADDR_WIDTH - 2;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic                live_q;
    logic                aw_full_q, w_full_q;
    logic                awready_q, wready_q;
    logic [IW-1:0]       aw_idx_q;
    logic [31:0]         wdata_q;
    logic [3:0]          wstrb_q;
    logic                bvalid_q, rvalid_q;
    logic [1:0]          bresp_q, rresp_q;
    logic [31:0]         rdata_q;
    logic [N_CFG-1:0]    stb_q;
    logic [32*N_CFG-1:0] cfg_q;
    logic [32*N_MON-1:0] mon_src;

    logic                aw_hs, w_hs, ar_hs, commit;
    logic [N_CFG-1:0]    wr_sel;
    logic                wr_ok;
    logic [IW-1:0]       ar_idx;
    logic [31:0]         rd_data;
    logic                rd_err;
    logic                unused_addr;

    assign unused_addr = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign cfg_wr_stb    = stb_q;
    assign cfg_regs      = cfg_q;

    assign aw_hs  = s_axi_awvalid && awready_q;
    assign w_hs   = s_axi_wvalid && wready_q;
    assign commit = aw_full_q && w_full_q && (!bvalid_q || s_axi_bready);
    assign s_axi_arready = live_q && (!rvalid_q || s_axi_rready);
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign ar_idx = s_axi_araddr[ADDR_WIDTH-1:2];

`ifdef OHS_MON_SNAPSHOT_EN
    localparam int unsigned CTL_IDX = N_CFG + N_MON;
    logic [32*N_MON-1:0] snap_q;
    logic                snap_go;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            snap_q <= '0;
        end else if (commit && snap_go) begin
            snap_q <= mon_regs;
        end
    end
    assign mon_src = snap_q;
`else
    assign mon_src = mon_regs;
`endif

    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < N_CFG; k++) begin
            wr_sel[k] = (aw_idx_q == IW'(k));
        end
        wr_ok = |wr_sel;
`ifdef OHS_MON_SNAPSHOT_EN
        snap_go = 1'b0;
        if (aw_idx_q == IW'(CTL_IDX)) begin
            wr_ok   = 1'b1;
            snap_go = wstrb_q[0] && wdata_q[0];
        end
`endif
    end

    // Unmapped indices fall through to zero data with SLVERR
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        for (int k = 0; k < N_CFG; k++) begin
            if (ar_idx == IW'(k)) begin
                rd_data = cfg_q[32*k +: 32];
                rd_err  = 1'b0;
            end
        end
        for (int k = 0; k < N_MON; k++) begin
            if (ar_idx == IW'(N_CFG + k)) begin
                rd_data = mon_src[32*k +: 32];
                rd_err  = 1'b0;
            end
        end
`ifdef OHS_MON_SNAPSHOT_EN
        if (ar_idx == IW'(CTL_IDX)) begin
            rd_err = 1'b0;
        end
`endif
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            live_q    <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            stb_q     <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            cfg_q     <= {N_CFG{CFG_RST_VAL}};
        end else begin
            live_q    <= 1'b1;
            awready_q <= !(aw_hs || (aw_full_q && !commit));
            wready_q  <= !(w_hs || (w_full_q && !commit));
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_idx_q  <= s_axi_awaddr[ADDR_WIDTH-1:2];
            end else if (commit) begin
                aw_full_q <= 1'b0;
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                wdata_q  <= s_axi_wdata;
                wstrb_q  <= s_axi_wstrb;
            end else if (commit) begin
                w_full_q <= 1'b0;
            end
            stb_q <= commit ? wr_sel : '0;
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? OKAY : SLVERR;
            end else if (s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            for (int k = 0; k < N_CFG; k++) begin
                for (int b = 0; b < 4; b++) begin
                    if (commit && wr_sel[k] && wstrb_q[b]) begin
                        cfg_q[32*k+8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_err ? SLVERR : OKAY;
            end else if (s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_ohs_regbank.sv
// Self-checking bench for axi_ohs_regbank: directed cases plus random traffic.
// A behavioural register-map model is compared against the DUT every cycle.
module tb_axi_ohs_regbank;
    localparam int NC = 4;
    localparam int NM = 5;
    localparam int AW = 6;
`ifdef OHS_MON_SNAPSHOT_EN
    localparam logic [31:0] EXP_MON0 = 32'h0;
    localparam logic [31:0] EXP_SNAP = 32'h11;
    localparam logic [31:0] EXP_CTL_RESP = 32'h0;
`else
    localparam logic [31:0] EXP_MON0 = 32'h12345678;
    localparam logic [31:0] EXP_SNAP = 32'h22;
    localparam logic [31:0] EXP_CTL_RESP = 32'h2;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]    awaddr = '0, araddr = '0;
    logic             awvalid = 0, wvalid = 0, bready = 0;
    logic             arvalid = 0, rready = 0;
    logic [31:0]      wdata = '0;
    logic [3:0]       wstrb = '0;
    logic [32*NM-1:0] mon = '0;
    logic             awready, wready, bvalid, arready, rvalid;
    logic [1:0]       bresp, rresp;
    logic [31:0]      rdata;
    logic [32*NC-1:0] cfg;
    logic [NC-1:0]    stb;

    int errors = 0;
    int checks = 0;

    axi_ohs_regbank #(.N_CFG(NC), .N_MON(NM), .ADDR_WIDTH(AW)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rstn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .cfg_regs(cfg), .cfg_wr_stb(stb), .mon_regs(mon)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model state (written only by the compare process)
    bit            m_live, m_awf, m_wf, m_bv, m_rv;
    logic [AW-1:0] m_awa;
    logic [31:0]   m_wd, m_rd;
    logic [3:0]    m_ws;
    logic [1:0]    m_br, m_rr;
    logic [31:0]   m_cfg[NC];
    logic [31:0]   m_snap[NM];
    logic [NC-1:0] m_stb;

    task automatic model_reset();
        m_live = 0; m_awf = 0; m_wf = 0; m_bv = 0; m_rv = 0;
        m_br = 0; m_rr = 0; m_rd = 0; m_stb = '0;
        for (int k = 0; k < NC; k++) m_cfg[k] = 32'h0;
        for (int k = 0; k < NM; k++) m_snap[k] = 32'h0;
    endtask

    task automatic model_read(input logic [AW-1:0] a, output logic [31:0] d,
                              output logic [1:0] r);
        int i;
        i = int'(a) / 4;
        d = 32'h0;
        r = 2'b10;
        if (i < NC) begin
            d = m_cfg[i];
            r = 2'b00;
        end else if (i < NC + NM) begin
`ifdef OHS_MON_SNAPSHOT_EN
            d = m_snap[i-NC];
`else
            d = mon[32*(i-NC) +: 32];
`endif
            r = 2'b00;
        end
`ifdef OHS_MON_SNAPSHOT_EN
        else if (i == NC + NM) begin
            r = 2'b00;
        end
`endif
    endtask

    task automatic model_step();
        bit commit, awhs, whs, arhs;
        int i;
        logic [NC-1:0] nstb;
        commit = m_awf && m_wf && (!m_bv || bready);
        awhs   = awvalid && m_live && !m_awf;
        whs    = wvalid && m_live && !m_wf;
        arhs   = arvalid && m_live && (!m_rv || rready);
        if (arhs) begin
            model_read(araddr, m_rd, m_rr);
            m_rv = 1;
        end else if (rready) begin
            m_rv = 0;
        end
        nstb = '0;
        if (commit) begin
            i = int'(m_awa) / 4;
            m_br = 2'b10;
            if (i < NC) begin
                for (int b = 0; b < 4; b++)
                    if (m_ws[b]) m_cfg[i][8*b +: 8] = m_wd[8*b +: 8];
                nstb[i] = 1'b1;
                m_br = 2'b00;
            end
`ifdef OHS_MON_SNAPSHOT_EN
            else if (i == NC + NM) begin
                m_br = 2'b00;
                if (m_ws[0] && m_wd[0])
                    for (int k = 0; k < NM; k++) m_snap[k] = mon[32*k +: 32];
            end
`endif
            m_bv = 1; m_awf = 0; m_wf = 0;
        end else if (bready) begin
            m_bv = 0;
        end
        m_stb = nstb;
        if (awhs) begin m_awf = 1; m_awa = awaddr; end
        if (whs) begin m_wf = 1; m_wd = wdata; m_ws = wstrb; end
        m_live = 1;
    endtask

    // Compare process: outputs are stable at the falling edge
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rstn) begin
                model_reset();
                chk("rst_bresp", 32'(bresp), 0);
                chk("rst_rresp", 32'(rresp), 0);
                chk("rst_rdata", rdata, 0);
            end
            chk("awready", 32'(awready), 32'(m_live && !m_awf));
            chk("wready", 32'(wready), 32'(m_live && !m_wf));
            chk("arready", 32'(arready), 32'(m_live && (!m_rv || rready)));
            chk("bvalid", 32'(bvalid), 32'(m_bv));
            if (m_bv) chk("bresp", 32'(bresp), 32'(m_br));
            chk("rvalid", 32'(rvalid), 32'(m_rv));
            if (m_rv) begin
                chk("rdata", rdata, m_rd);
                chk("rresp", 32'(rresp), 32'(m_rr));
            end
            for (int k = 0; k < NC; k++) chk("cfg_regs", cfg[32*k +: 32], m_cfg[k]);
            chk("cfg_wr_stb", 32'(stb), 32'(m_stb));
            if (rstn) model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int lead,
                            output logic [1:0] resp, output int lat,
                            output logic [NC-1:0] st);
        bit got, haw, hw;
        got = 0; resp = '1; lat = -1; st = '1;
        wvalid = 1; wdata = d; wstrb = s;
        awaddr = a; awvalid = (lead == 0); bready = 1;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            if (lead == 3 && n == 1) chk("wready_held", 32'(wready), 0);
            if (lead == 3 && n == 4) chk("awready_held", 32'(awready), 0);
            if (bvalid) begin got = 1; resp = bresp; lat = n; st = stb; end
            haw = awvalid && awready;
            hw  = wvalid && wready;
            tick();
            if (haw) awvalid = 0;
            if (hw) wvalid = 0;
            if (n + 1 == lead) awvalid = 1;
        end
        chk("wr_done", 32'(got), 1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d,
                           output logic [1:0] r);
        bit sent, got, h;
        sent = 0; got = 0; d = '1; r = '1;
        arvalid = 1; araddr = a; rready = 1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (sent && rvalid) begin d = rdata; r = rresp; got = 1; end
            h = arvalid && arready;
            tick();
            if (h) begin arvalid = 0; sent = 1; end
        end
        chk("rd_done", 32'(got), 1);
    endtask

    task automatic rand_traffic(input int cycles);
        bit haw, hw, har;
        int j;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            haw = awvalid && awready;
            hw  = wvalid && wready;
            har = arvalid && arready;
            tick();
            if (!awvalid || haw) begin
                awvalid = ($urandom_range(0, 2) != 0);
                awaddr  = AW'($urandom);
            end
            if (!wvalid || hw) begin
                wvalid = ($urandom_range(0, 2) != 0);
                wdata  = $urandom;
                wstrb  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            end
            if (!arvalid || har) begin
                arvalid = ($urandom_range(0, 1) != 0);
                araddr  = AW'($urandom);
            end
            bready = ($urandom_range(0, 3) != 0);
            rready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                j = $urandom_range(0, NM - 1);
                mon[32*j +: 32] = $urandom;
            end
        end
        awvalid = 0; wvalid = 0; arvalid = 0;
        bready = 1; rready = 1;
        repeat (4) tick();
    endtask

    logic [1:0]    resp;
    logic [31:0]   rd;
    logic [NC-1:0] st;
    int            lat;

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst_awready_lit", 32'(awready), 0);
        chk("rst_arready_lit", 32'(arready), 0);
        chk("rst_cfg0_lit", cfg[31:0], 0);
        tick();
        rstn = 1;
        repeat (2) tick();

        do_write(6'h00, 32'h3F800000, 4'hF, 0, resp, lat, st);
        chk("w0_bresp", 32'(resp), 0);
        chk("w0_latency", lat, 2);
        chk("w0_stb", 32'(st), 32'h1);
        @(negedge clk);
        chk("w0_cfg0", cfg[31:0], 32'h3F800000);
        chk("w0_stb_gone", 32'(stb), 0);
        tick();

        do_write(6'h04, 32'hAABBCCDD, 4'b0101, 3, resp, lat, st);
        chk("w1_bresp", 32'(resp), 0);
        chk("w1_stb", 32'(st), 32'h2);
        @(negedge clk);
        chk("w1_cfg1", cfg[63:32], 32'h00BB00DD);
        tick();

        mon[31:0] = 32'h12345678;
        do_read(6'h10, rd, resp);
        chk("r_mon0", rd, EXP_MON0);
        chk("r_mon0_resp", 32'(resp), 0);
        do_read(6'h3C, rd, resp);
        chk("r_oor_data", rd, 0);
        chk("r_oor_resp", 32'(resp), 32'h2);
        do_read(6'h04, rd, resp);
        chk("r_cfg1", rd, 32'h00BB00DD);

        do_write(6'h10, 32'hFFFFFFFF, 4'hF, 0, resp, lat, st);
        chk("w_mon_bresp", 32'(resp), 32'h2);
        chk("w_mon_stb", 32'(st), 0);
        do_read(6'h10, rd, resp);
        chk("w_mon_readback", rd, EXP_MON0);

        do_write(6'h08, 32'h5A5A5A5A, 4'h0, 0, resp, lat, st);
        chk("w_nostrb_bresp", 32'(resp), 0);
        chk("w_nostrb_stb", 32'(st), 32'h4);
        chk("w_nostrb_cfg2", cfg[95:64], 0);

        // Back-pressure on B with a second write queued behind it
        begin
            bit haw, hw;
            int na, nw, nb;
            na = 0; nw = 0; nb = 0;
            bready = 0;
            awvalid = 1; awaddr = 6'h08;
            wvalid = 1; wdata = 32'h000000A1; wstrb = 4'hF;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (n == 4) begin
                    chk("stall_awready", 32'(awready), 0);
                    chk("stall_bvalid", 32'(bvalid), 1);
                end
                if (bvalid && bready) nb++;
                haw = awvalid && awready;
                hw  = wvalid && wready;
                tick();
                if (haw) begin na++; awvalid = (na < 2); awaddr = 6'h0C; end
                if (hw) begin nw++; wvalid = (nw < 2); wdata = 32'h000000B2; end
                bready = (n >= 5);
            end
            chk("stall_nresp", nb, 2);
            chk("stall_cfg2", cfg[95:64], 32'h000000A1);
            chk("stall_cfg3", cfg[127:96], 32'h000000B2);
        end

        mon[31:0] = 32'h11;
        do_write(6'h24, 32'h1, 4'hF, 0, resp, lat, st);
        chk("ctl_bresp", 32'(resp), EXP_CTL_RESP);
        mon[31:0] = 32'h22;
        do_read(6'h10, rd, resp);
        chk("snap_mon0", rd, EXP_SNAP);
        do_read(6'h24, rd, resp);
        chk("ctl_read_data", rd, 0);
        chk("ctl_read_resp", 32'(resp), EXP_CTL_RESP);

        // Reset while a read response is pending
        rready = 0; arvalid = 1; araddr = 6'h00;
        tick();
        arvalid = 0;
        @(negedge clk);
        chk("mid_rvalid", 32'(rvalid), 1);
        chk("mid_rdata", rdata, 32'h3F800000);
        @(posedge clk);
        #3;
        rstn = 0;
        #1;
        chk("mid_rst_rvalid", 32'(rvalid), 0);
        chk("mid_rst_cfg0", cfg[31:0], 0);
        repeat (2) tick();
        rstn = 1;
        rready = 1;
        repeat (2) tick();

        rand_traffic(1500);
        rstn = 0;
        repeat (2) tick();
        rstn = 1;
        repeat (2) tick();
        rand_traffic(1500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
